// File: rtl/trakball_quad_gen_pkg.sv
// Shared definitions for the trakball step generator: step-FSM states, trakball bus
// bit positions (also used by the misc I/O decode) and the saturating accumulator add.
package trakball_quad_gen_pkg;

    typedef logic [1:0] axis_state_t;

    localparam axis_state_t ST_IDLE  = 2'd0;
    localparam axis_state_t ST_SETUP = 2'd1;
    localparam axis_state_t ST_HIGH  = 2'd2;
    localparam axis_state_t ST_LOW   = 2'd3;

    localparam int TB_S1_H_DIR = 7;
    localparam int TB_S2_H_DIR = 6;
    localparam int TB_S1_H_CK  = 5;
    localparam int TB_S2_H_CK  = 4;
    localparam int TB_S1_V_DIR = 3;
    localparam int TB_S2_V_DIR = 2;
    localparam int TB_S1_V_CK  = 1;
    localparam int TB_S2_V_CK  = 0;

    typedef struct packed {
        logic dir;
        logic ck;
    } axis_drive_t;

    // Add and consume are applied together, then the result is clamped symmetrically.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] acc,
                                                   input logic signed [31:0] delta,
                                                   input logic signed [31:0] consume,
                                                   input int accWidth);
        logic signed [31:0] sum;
        logic signed [31:0] lim;
        sum = acc + delta - consume;
        lim = (32'sd1 <<< (accWidth - 1)) - 32'sd1;
        if (sum > lim) return lim;
        if (sum < -lim) return -lim;
        return sum;
    endfunction

endpackage

// File: rtl/trakball_quad_gen_if.sv
// Motion packet bus from the mouse front end into the trakball step generator.
interface trakball_quad_gen_if;
    logic              mouse_strobe;
    logic signed [8:0] mouse_dx;
    logic signed [8:0] mouse_dy;

    modport master (output mouse_strobe, output mouse_dx, output mouse_dy);
    modport slave  (input  mouse_strobe, input  mouse_dx, input  mouse_dy);
endinterface

// File: rtl/trakball_quad_gen_axis.sv
// One trakball axis: signed saturating motion accumulator feeding a dir/ck step FSM.
// Outputs are next-state values so the top can register them without extra latency.
module quad_axis_gen
    import trakball_quad_gen_pkg::*;
#(
    parameter int ACC_W    = 10,
    parameter int SETUP_TK = 1,
    parameter int HIGH_TK  = 2,
    parameter int LOW_TK   = 2,
    parameter int INV      = 0
) (
    input  logic              clk_cpu_4x,
    input  logic              reset,
    input  logic              tick_i,
    input  logic              flush_i,
    input  logic              strobe_i,
    input  logic signed [8:0] delta_i,
    output logic              ckNext_o,
    output logic              dirNext_o,
    output logic              busyNext_o,
    output logic              idle_o
);

    axis_state_t              state_q, state_d;
    logic [7:0]               phase_q, phase_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     dir_q, dir_d;
    logic                     startStep;
    logic                     accPos;
    logic signed [31:0]       addend;
    logic signed [31:0]       consume;

    assign accPos = !acc_q[ACC_W-1] && (acc_q != '0);

    // The tick that ends LOW doubles as the IDLE decision, so back-to-back steps
    // repeat every 1 + SETUP_TK + HIGH_TK + LOW_TK - 1 ticks.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        dir_d     = dir_q;
        startStep = 1'b0;
        if (tick_i) begin
            case (state_q)
                ST_IDLE:  startStep = (acc_q != '0);
                ST_SETUP: begin
                    if (phase_q == 8'(SETUP_TK - 1)) begin
                        state_d = ST_HIGH;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (phase_q == 8'(HIGH_TK - 1)) begin
                        state_d = ST_LOW;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
                ST_LOW: begin
                    if (phase_q == 8'(LOW_TK - 1)) begin
                        state_d   = ST_IDLE;
                        phase_d   = '0;
                        startStep = (acc_q != '0);
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
        if (startStep) begin
            state_d = ST_SETUP;
            phase_d = '0;
            dir_d   = accPos ^ (INV != 0);
        end
        addend  = strobe_i ? 32'(delta_i) : 32'sd0;
        consume = startStep ? (accPos ? 32'sd1 : -32'sd1) : 32'sd0;
        acc_d   = ACC_W'(sat_add(32'(acc_q), addend, consume, ACC_W));
        if (flush_i) begin
            state_d = ST_IDLE;
            phase_d = '0;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk_cpu_4x or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            acc_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            acc_q   <= acc_d;
            dir_q   <= dir_d;
        end
    end

    assign ckNext_o   = (state_d == ST_HIGH);
    assign dirNext_o  = dir_d;
    assign busyNext_o = (acc_d != '0) || (state_d != ST_IDLE);
    assign idle_o     = (state_q == ST_IDLE);

endmodule

// File: rtl/trakball_quad_gen.sv
// Mini-Trak Ball transmitter: turns host dx/dy packets into dir/ck step trains on the
// 8-bit trakball bus, routed to player 1, player 2, or mirrored to both.
module trakball_quad_gen
    import trakball_quad_gen_pkg::*;
#(
    parameter int ACC_W    = 10,
    parameter int TICK_DIV = 6,
    parameter int SETUP_TK = 1,
    parameter int HIGH_TK  = 2,
    parameter int LOW_TK   = 2,
    parameter int INV_H    = 0,
    parameter int INV_V    = 0
) (
    input  logic                 clk_cpu_4x,
    input  logic                 reset,
    trakball_quad_gen_if.slave   mouse,
    input  logic                 player_sel,
    input  logic                 mirror,
    input  logic                 flush,
    output logic [7:0]           trakball_o,
    output logic                 busy_o
);

    logic [7:0]  tickCnt_q;
    logic        tick;
    axis_drive_t hDrive, vDrive;
    logic        hBusy, vBusy, hIdle, vIdle;
    logic        sel_q, mirror_q;
    logic        selNow, mirrorNow, drive1, drive2;
    logic [7:0]  trakball_q, trakball_d;
    logic        busy_q;

    assign tick = (tickCnt_q == 8'(TICK_DIV - 1));

    always_ff @(posedge clk_cpu_4x or posedge reset) begin
        if (reset) tickCnt_q <= '0;
        else       tickCnt_q <= tick ? '0 : tickCnt_q + 8'd1;
    end

    quad_axis_gen #(
        .ACC_W(ACC_W), .SETUP_TK(SETUP_TK), .HIGH_TK(HIGH_TK), .LOW_TK(LOW_TK), .INV(INV_H)
    ) uAxisH (
        .clk_cpu_4x(clk_cpu_4x), .reset(reset), .tick_i(tick), .flush_i(flush),
        .strobe_i(mouse.mouse_strobe), .delta_i(mouse.mouse_dx),
        .ckNext_o(hDrive.ck), .dirNext_o(hDrive.dir), .busyNext_o(hBusy), .idle_o(hIdle)
    );

    quad_axis_gen #(
        .ACC_W(ACC_W), .SETUP_TK(SETUP_TK), .HIGH_TK(HIGH_TK), .LOW_TK(LOW_TK), .INV(INV_V)
    ) uAxisV (
        .clk_cpu_4x(clk_cpu_4x), .reset(reset), .tick_i(tick), .flush_i(flush),
        .strobe_i(mouse.mouse_strobe), .delta_i(mouse.mouse_dy),
        .ckNext_o(vDrive.ck), .dirNext_o(vDrive.dir), .busyNext_o(vBusy), .idle_o(vIdle)
    );

    // Routing only follows player_sel/mirror while both axes sit in IDLE, so a step
    // always finishes on the lines it started on. Undriven dir lines keep their value.
    always_comb begin
        selNow    = (hIdle && vIdle) ? player_sel : sel_q;
        mirrorNow = (hIdle && vIdle) ? mirror     : mirror_q;
        drive1    = mirrorNow || !selNow;
        drive2    = mirrorNow || selNow;
        trakball_d = trakball_q;
        trakball_d[TB_S1_H_CK] = 1'b0;
        trakball_d[TB_S2_H_CK] = 1'b0;
        trakball_d[TB_S1_V_CK] = 1'b0;
        trakball_d[TB_S2_V_CK] = 1'b0;
        if (drive1) begin
            trakball_d[TB_S1_H_DIR] = hDrive.dir;
            trakball_d[TB_S1_H_CK]  = hDrive.ck;
            trakball_d[TB_S1_V_DIR] = vDrive.dir;
            trakball_d[TB_S1_V_CK]  = vDrive.ck;
        end
        if (drive2) begin
            trakball_d[TB_S2_H_DIR] = hDrive.dir;
            trakball_d[TB_S2_H_CK]  = hDrive.ck;
            trakball_d[TB_S2_V_DIR] = vDrive.dir;
            trakball_d[TB_S2_V_CK]  = vDrive.ck;
        end
    end

    always_ff @(posedge clk_cpu_4x or posedge reset) begin
        if (reset) begin
            sel_q      <= 1'b0;
            mirror_q   <= 1'b0;
            trakball_q <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            sel_q      <= selNow;
            mirror_q   <= mirrorNow;
            trakball_q <= trakball_d;
            busy_q     <= hBusy || vBusy;
        end
    end

    assign trakball_o = trakball_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_trakball_quad_gen.sv
// Self-checking bench for trakball_quad_gen: a receiver model counts steps per line and
// the expected counts come from the signed motion deltas and the step timing rules.
module tb_trakball_quad_gen;

    localparam int CK_BIT [4] = '{5, 4, 1, 0};

    logic       clk = 1'b0;
    logic       reset;
    logic       player_sel, mirror, flush;
    logic [7:0] tbo0, tbo1;
    logic       busy0, busy1;

    trakball_quad_gen_if mif0();
    trakball_quad_gen_if mif1();

    trakball_quad_gen #(.INV_H(0)) dut0 (
        .clk_cpu_4x(clk), .reset(reset), .mouse(mif0), .player_sel(player_sel),
        .mirror(mirror), .flush(flush), .trakball_o(tbo0), .busy_o(busy0)
    );

    trakball_quad_gen #(.INV_H(1)) dut1 (
        .clk_cpu_4x(clk), .reset(reset), .mouse(mif1), .player_sel(player_sel),
        .mirror(mirror), .flush(flush), .trakball_o(tbo1), .busy_o(busy1)
    );

    always #5 clk = ~clk;

    int posCnt = 0;
    always @(posedge clk) begin
        if (reset) posCnt <= 0;
        else       posCnt <= posCnt + 1;
    end

    // Receiver model: per line rise count, 4-bit up/down counter, pulse width and dir setup.
    int         cyc = 0;
    int         riseCnt [2][4] = '{default: 0};
    logic [3:0] recvCnt [2][4] = '{default: 4'h0};
    int         dirAge  [2][4] = '{default: 1000};
    int         highLen [2][4] = '{default: 0};
    int         lastRise[2][4] = '{default: 0};
    logic [7:0] prevTb  [2]    = '{default: 8'h00};
    int         badWidth = 0;
    int         badSetup = 0;
    int         rise0Times[$];

    always @(negedge clk) begin
        logic [7:0] cur;
        int k;
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            cur = (d == 0) ? tbo0 : tbo1;
            for (int i = 0; i < 4; i++) begin
                k = CK_BIT[i];
                if (cur[k+2] != prevTb[d][k+2]) dirAge[d][i] = 0;
                else                            dirAge[d][i] = dirAge[d][i] + 1;
                if (cur[k] && !prevTb[d][k]) begin
                    riseCnt[d][i] = riseCnt[d][i] + 1;
                    recvCnt[d][i] = recvCnt[d][i] + (cur[k+2] ? 4'd1 : 4'hF);
                    if (dirAge[d][i] < 6) badSetup = badSetup + 1;
                    lastRise[d][i] = cyc;
                    highLen[d][i]  = 1;
                    if (d == 0 && i == 0) rise0Times.push_back(cyc);
                end else if (cur[k]) begin
                    highLen[d][i] = highLen[d][i] + 1;
                end else if (prevTb[d][k] && highLen[d][i] != 12) begin
                    badWidth = badWidth + 1;
                end
            end
            prevTb[d] = cur;
        end
    end

    int         tests = 0;
    int         failures = 0;
    logic [3:0] expCnt [4] = '{default: 4'h0};
    int         base [4];

    task automatic checkOutput(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tickStep();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int d, input int dx, input int dy);
        if (d == 0) begin
            mif0.mouse_dx = 9'(dx); mif0.mouse_dy = 9'(dy); mif0.mouse_strobe = 1'b1;
        end else begin
            mif1.mouse_dx = 9'(dx); mif1.mouse_dy = 9'(dy); mif1.mouse_strobe = 1'b1;
        end
        tickStep();
        mif0.mouse_strobe = 1'b0;
        mif1.mouse_strobe = 1'b0;
    endtask

    task automatic waitIdle(input int d, input int budget, input string tag, output int fallCyc);
        int n = 0;
        while (((d == 0) ? busy0 : busy1) && n < budget) begin
            tickStep();
            n++;
        end
        fallCyc = cyc;
        checkOutput({tag, " idle"}, int'((d == 0) ? busy0 : busy1), 0);
    endtask

    task automatic alignTo(input int r);
        int n = 0;
        while ((posCnt % 6) != r && n < 12) begin
            tickStep();
            n++;
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) base[i] = riseCnt[0][i];
    endtask

    task automatic modelAdd(input int i, input int delta);
        expCnt[i] = expCnt[i] + 4'(delta);
    endtask

    initial begin
        int fall;
        int nr;
        int w;
        reset = 1'b1;
        player_sel = 1'b0; mirror = 1'b0; flush = 1'b0;
        mif0.mouse_strobe = 1'b0; mif0.mouse_dx = '0; mif0.mouse_dy = '0;
        mif1.mouse_strobe = 1'b0; mif1.mouse_dx = '0; mif1.mouse_dy = '0;
        repeat (3) tickStep();
        checkOutput("reset tb0", int'(tbo0), 0);
        checkOutput("reset busy0", int'(busy0), 0);
        checkOutput("reset tb1", int'(tbo1), 0);
        checkOutput("reset busy1", int'(busy1), 0);
        reset = 1'b0;
        repeat (4) tickStep();

        // dx = +3 on player 1
        snap();
        nr = rise0Times.size();
        applyStimulus(0, 3, 0);
        checkOutput("dx3 busy", int'(busy0), 1);
        waitIdle(0, 300, "dx3", fall);
        modelAdd(0, 3);
        checkOutput("dx3 rises", riseCnt[0][0] - base[0], 3);
        checkOutput("dx3 other", riseCnt[0][1] + riseCnt[0][2] + riseCnt[0][3]
                                 - base[1] - base[2] - base[3], 0);
        checkOutput("dx3 recv", int'(recvCnt[0][0]), int'(expCnt[0]));
        checkOutput("dx3 npulse", rise0Times.size() - nr, 3);
        if (rise0Times.size() - nr == 3) begin
            checkOutput("dx3 gap1", rise0Times[nr+1] - rise0Times[nr], 30);
            checkOutput("dx3 gap2", rise0Times[nr+2] - rise0Times[nr+1], 30);
        end
        checkOutput("dx3 busy fall", fall - lastRise[0][0], 24);
        checkOutput("dx3 dir", int'(tbo0[7]), 1);
        checkOutput("dx3 width", badWidth, 0);
        checkOutput("dx3 setup", badSetup, 0);

        // dy = -2 on player 2
        player_sel = 1'b1;
        tickStep();
        snap();
        applyStimulus(0, 0, -2);
        waitIdle(0, 300, "dy-2", fall);
        modelAdd(3, -2);
        checkOutput("dy-2 rises", riseCnt[0][3] - base[3], 2);
        checkOutput("dy-2 recv", int'(recvCnt[0][3]), 14);
        checkOutput("dy-2 p2 dir", int'(tbo0[2]), 0);
        checkOutput("dy-2 p1 vck", riseCnt[0][2] - base[2], 0);
        checkOutput("dy-2 p1 vlines", int'(tbo0[3]) + int'(tbo0[1]), 0);

        // Saturation: three +255 strobes between ticks
        player_sel = 1'b0;
        tickStep();
        snap();
        alignTo(0);
        mif0.mouse_dx = 9'sd255; mif0.mouse_dy = '0; mif0.mouse_strobe = 1'b1;
        repeat (3) tickStep();
        mif0.mouse_strobe = 1'b0;
        waitIdle(0, 16000, "sat", fall);
        modelAdd(0, 511);
        checkOutput("sat rises", riseCnt[0][0] - base[0], 511);
        checkOutput("sat recv", int'(recvCnt[0][0]), int'(expCnt[0]));

        // Strobe +1 on the very tick that consumes acc = +1
        snap();
        alignTo(0);
        applyStimulus(0, 1, 0);
        alignTo(5);
        applyStimulus(0, 1, 0);
        waitIdle(0, 300, "concur", fall);
        modelAdd(0, 2);
        checkOutput("concur rises", riseCnt[0][0] - base[0], 2);
        checkOutput("concur recv", int'(recvCnt[0][0]), int'(expCnt[0]));

        // player_sel toggled mid-pulse
        snap();
        applyStimulus(0, 1, 0);
        w = 0;
        while (!tbo0[5] && w < 100) begin tickStep(); w++; end
        checkOutput("toggle saw high", int'(tbo0[5]), 1);
        player_sel = 1'b1;
        waitIdle(0, 300, "toggle1", fall);
        checkOutput("toggle p1 rises", riseCnt[0][0] - base[0], 1);
        checkOutput("toggle p2 none", riseCnt[0][1] - base[1], 0);
        applyStimulus(0, 1, 0);
        waitIdle(0, 300, "toggle2", fall);
        modelAdd(0, 1);
        modelAdd(1, 1);
        checkOutput("toggle p2 rises", riseCnt[0][1] - base[1], 1);
        checkOutput("toggle p1 held", riseCnt[0][0] - base[0], 1);
        checkOutput("toggle width", badWidth, 0);

        // Random motion on random routing, checked against the receiver counters
        for (int it = 0; it < 8; it++) begin
            int dx, dy, mag;
            logic s, m;
            dx = int'($urandom_range(12)) - 6;
            dy = int'($urandom_range(12)) - 6;
            s  = 1'($urandom_range(1));
            m  = ($urandom_range(3) == 0);
            player_sel = s; mirror = m;
            tickStep(); tickStep();
            snap();
            applyStimulus(0, dx, dy);
            mag = (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy);
            waitIdle(0, 36 * mag + 100, "rand", fall);
            if (m || !s) begin modelAdd(0, dx); modelAdd(2, dy); end
            if (m || s)  begin modelAdd(1, dx); modelAdd(3, dy); end
            for (int i = 0; i < 4; i++) begin
                int ex, dl;
                dl = (i < 2) ? dx : dy;
                ex = (dl < 0) ? -dl : dl;
                if (!(m || (((i % 2) == 1) == s))) ex = 0;
                checkOutput($sformatf("rand%0d rise%0d", it, i), riseCnt[0][i] - base[i], ex);
                checkOutput($sformatf("rand%0d cnt%0d", it, i), int'(recvCnt[0][i]), int'(expCnt[i]));
            end
        end
        checkOutput("rand width", badWidth, 0);
        checkOutput("rand setup", badSetup, 0);

        // Mirror with inverted H direction on dut1
        player_sel = 1'b0; mirror = 1'b1;
        tickStep(); tickStep();
        applyStimulus(1, -1, 0);
        waitIdle(1, 300, "mirror", fall);
        checkOutput("mirror p1 rise", riseCnt[1][0], 1);
        checkOutput("mirror p2 rise", riseCnt[1][1], 1);
        checkOutput("mirror same time", lastRise[1][0] - lastRise[1][1], 0);
        checkOutput("mirror dirs", int'(tbo1[7:6]), 3);
        checkOutput("mirror recv", int'(recvCnt[1][0]), 1);
        checkOutput("mirror v quiet", riseCnt[1][2] + riseCnt[1][3], 0);

        // flush during SETUP aborts the step
        alignTo(0);
        applyStimulus(1, -1, 0);
        repeat (6) tickStep();
        checkOutput("flush pre busy", int'(busy1), 1);
        flush = 1'b1;
        tickStep();
        flush = 1'b0;
        checkOutput("flush busy", int'(busy1), 0);
        checkOutput("flush ck", int'(tbo1[5]) + int'(tbo1[4]), 0);
        repeat (60) tickStep();
        checkOutput("flush no pulse", riseCnt[1][0] + riseCnt[1][1], 2);
        checkOutput("flush dir held", int'(tbo1[7:6]), 3);
        checkOutput("flush still idle", int'(busy1), 0);
        checkOutput("final width", badWidth, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
